mips_cpu_lsu: RTL and testbench

MIPS_CPU_LSU -- requirements
Module: mips_cpu_lsu

---
 rtl/mips_cpu_lsu.sv | 178 +++++++++++++++++
 tb/tb_mips_cpu_lsu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: turns single CPU byte/half/word/dword requests into one Avalon-MM
// access with lane steering, load extension, misalignment and stall-timeout errors.
module mips_cpu_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [DATA_W-1:0] readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       stall_q, stall_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [OFF_W-1:0]  off;

  assign off = addr_q[OFF_W-1:0];

  function automatic logic misalign(input logic [2:0] low, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return low[0];
      2'd2:    return |low[1:0];
      default: return (|low) || (DATA_W == 32);
    endcase
  endfunction

  function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] size,
                                                 input logic [OFF_W-1:0] offs);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return BE_W'(m) << offs;
  endfunction

  // Left-justify the access width, then shift back arithmetically or logically.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                 input logic [1:0] size,
                                                 input logic sgn);
    logic        [DATA_W-1:0] up;
    logic signed [DATA_W-1:0] s;
    int sa;
    sa = DATA_W - (8 << size);
    if (sa <= 0) return raw;
    up = raw << sa;
    s  = up;
    if (sgn) begin
      s = s >>> sa;
      return s;
    end
    return up >> sa;
  endfunction

  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    err_d      = err_q;
    addr_d     = addr_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sgn_d   = req_signed;
          wr_d    = req_write;
          wdata_d = req_wdata;
          rdata_d = '0;
          stall_d = '0;
          if (misalign(req_addr[2:0], req_size)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        read       = !wr_q;
        write      = wr_q;
        address    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        byteenable = lane_mask(size_q, off);
        writedata  = wdata_q << {off, 3'b000};
        if (!waitrequest) begin
          if (!wr_q) rdata_d = load_ext(readdata >> {off, 3'b000}, size_q, sgn_q);
          state_d = RESP;
        end else begin
          stall_d = stall_q + 16'd1;
          // rdata stays zero on timeout, so the error response carries no data
          if (stall_d == 16'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  // Request payload is only observed through state-gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Randomized bench for mips_cpu_lsu: a 32-bit and a 64-bit instance checked against
// an arithmetic model of lane steering, load extension, alignment and timeout.
module tb_mips_cpu_lsu;
  localparam int TO32 = 4;
  localparam int TO64 = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_write, req_signed, req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, read, write, waitrequest;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic [3:0]  byteenable;

  logic        w_req_valid, w_req_write, w_req_signed, w_req_ready;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic        w_resp_valid, w_resp_err, w_read, w_write, w_waitrequest;
  logic [63:0] w_resp_rdata, w_writedata, w_readdata;
  logic [31:0] w_address;
  logic [7:0]  w_byteenable;

  mips_cpu_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  mips_cpu_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_size(w_req_size), .req_signed(w_req_signed), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata),
    .resp_err(w_resp_err), .address(w_address), .read(w_read), .write(w_write),
    .waitrequest(w_waitrequest), .writedata(w_writedata), .byteenable(w_byteenable),
    .readdata(w_readdata)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] obs_addr, obs_be, obs_wd, obs_rdata;
  logic        obs_err;
  int          obs_wcnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_misaligned(input logic [31:0] a, input int sz, input int dw);
    return ((a % (32'd1 << sz)) != 0) || (sz == 3 && dw == 32);
  endfunction

  function automatic logic [63:0] m_be(input logic [31:0] a, input int sz, input int dw);
    return ((64'd1 << (1 << sz)) - 64'd1) << (a % (dw / 8));
  endfunction

  function automatic logic [63:0] m_wd(input logic [63:0] wd, input logic [31:0] a, input int dw);
    logic [63:0] v;
    v = wd << (8 * (a % (dw / 8)));
    return (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [31:0] a,
                                         input int sz, input bit sgn, input int dw);
    logic [63:0] v;
    int bits;
    bits = 8 << sz;
    v = rd >> (8 * (a % (dw / 8)));
    if (bits < 64) begin
      v = v % (64'd1 << bits);
      if (sgn && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  // ---------------- 32-bit transaction ----------------
  task automatic do_txn32(input bit wr, input int sz, input bit sgn, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int nstall);
    bit mis, tmo;
    int cyc;
    mis = m_misaligned(a, sz, 32);
    tmo = !mis && (nstall >= TO32);
    cyc = tmo ? TO32 : nstall + 1;
    obs_wcnt = 0;
    @(negedge clk);
    chk("ready32", req_ready, 1);
    chk("idle_vld32", resp_valid, 0);
    req_valid = 1'b1; req_write = wr; req_size = 2'(sz); req_signed = sgn;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!mis) begin
      for (int i = 0; i < cyc; i++) begin
        if (i > 0) @(negedge clk);
        waitrequest = (i < nstall);
        readdata = (i < nstall) ? $urandom : rd;
        chk("read32", read, !wr);
        chk("write32", write, wr);
        chk("addr32", address, a & ~32'h3);
        chk("be32", byteenable, m_be(a, sz, 32));
        chk("wdata32", writedata, m_wd({32'd0, wd}, a, 32));
        obs_addr = address; obs_be = byteenable; obs_wd = writedata;
        if (write) obs_wcnt++;
      end
      @(negedge clk);
    end
    waitrequest = 1'b0;
    chk("rvld32", resp_valid, 1);
    chk("rerr32", resp_err, mis || tmo);
    chk("rdata32", resp_rdata, (wr || mis || tmo) ? 64'd0 : m_load({32'd0, rd}, a, sz, sgn, 32));
    chk("busoff32", {read, write, byteenable}, 0);
    obs_rdata = resp_rdata; obs_err = resp_err;
  endtask

  // ---------------- 64-bit transaction (no stall) ----------------
  task automatic do_txn64(input bit wr, input int sz, input bit sgn, input logic [31:0] a,
                          input logic [63:0] wd, input logic [63:0] rd);
    bit mis;
    mis = m_misaligned(a, sz, 64);
    @(negedge clk);
    chk("ready64", w_req_ready, 1);
    w_req_valid = 1'b1; w_req_write = wr; w_req_size = 2'(sz); w_req_signed = sgn;
    w_req_addr = a; w_req_wdata = wd;
    @(negedge clk);
    w_req_valid = 1'b0; w_req_addr = $urandom; w_req_wdata = {$urandom, $urandom};
    if (!mis) begin
      w_waitrequest = 1'b0;
      w_readdata = rd;
      chk("read64", w_read, !wr);
      chk("write64", w_write, wr);
      chk("addr64", w_address, a & ~32'h7);
      chk("be64", w_byteenable, m_be(a, sz, 64));
      chk("wdata64", w_writedata, m_wd(wd, a, 64));
      obs_be = w_byteenable;
      @(negedge clk);
      w_readdata = {$urandom, $urandom};
    end
    chk("rvld64", w_resp_valid, 1);
    chk("rerr64", w_resp_err, mis);
    chk("rdata64", w_resp_rdata, (wr || mis) ? 64'd0 : m_load(rd, a, sz, sgn, 64));
    obs_rdata = w_resp_rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit          wr, sgn;
    int          sz, r, ns;
    logic [31:0] a;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    waitrequest = 0; readdata = 0;
    w_req_valid = 0; w_req_write = 0; w_req_size = 0; w_req_signed = 0; w_req_addr = 0;
    w_req_wdata = 0; w_waitrequest = 0; w_readdata = 0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_vld", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_rw", {read, write}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_addr", address, 0);
    chk("rst_wd", writedata, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_ready64", w_req_ready, 1);
    reset = 1'b1;

    // signed byte load from the top lane
    do_txn32(0, 0, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 0);
    chk("lb_addr", obs_addr, 32'h1000);
    chk("lb_be", obs_be, 4'b1000);
    chk("lb_rdata", obs_rdata, 32'hFFFF_FF80);

    // half store stalled three cycles
    do_txn32(1, 1, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 3);
    chk("sh_wcyc", obs_wcnt, 4);
    chk("sh_wd", obs_wd, 32'hBEEF_0000);
    chk("sh_be", obs_be, 4'b1100);
    chk("sh_err", obs_err, 0);

    // misaligned word, then dword on a 32-bit bus
    do_txn32(0, 2, 0, 32'h0006, 32'h0, 32'h1234_5678, 0);
    chk("mis_err", obs_err, 1);
    do_txn32(0, 3, 0, 32'h0008, 32'h0, 32'h1234_5678, 0);
    chk("d32_err", obs_err, 1);

    // stuck waitrequest times out, then a normal access is accepted
    do_txn32(0, 2, 0, 32'h0100, 32'h0, 32'hDEAD_BEEF, 50);
    chk("tmo_err", obs_err, 1);
    do_txn32(0, 2, 0, 32'h0104, 32'h0, 32'hCAFE_F00D, 0);
    chk("post_tmo", obs_rdata, 32'hCAFE_F00D);

    // reset during a stalled store
    @(negedge clk);
    req_valid = 1; req_write = 1; req_size = 2'd2; req_signed = 0;
    req_addr = 32'h40; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 0; waitrequest = 1;
    chk("ra_write1", write, 1);
    @(negedge clk);
    chk("ra_write2", write, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("ra_rw", {read, write}, 0);
    chk("ra_be", byteenable, 0);
    chk("ra_vld", resp_valid, 0);
    reset = 1'b1; waitrequest = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ra_novld", resp_valid, 0);
      chk("ra_ready", req_ready, 1);
    end

    // randomized 32-bit traffic
    for (int k = 0; k < 80; k++) begin
      wr = 1'($urandom); sgn = 1'($urandom);
      sz = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      r = $urandom_range(0, 9);
      ns = (r <= 5) ? 0 : (r == 9) ? TO32 + 2 : r - 5;
      do_txn32(wr, sz, sgn, a, $urandom, $urandom, ns);
    end

    // 64-bit bus: dword load returns readdata untouched
    do_txn64(0, 3, 0, 32'h0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF);
    chk("ld_be", obs_be, 8'hFF);
    chk("ld_rdata", obs_rdata, 64'h0123_4567_89AB_CDEF);
    do_txn64(0, 0, 1, 32'h0000_000D, 64'h0, 64'h1122_F344_5566_7788);
    chk("lb64_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_FFF3);
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom); sgn = 1'($urandom);
      sz = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      do_txn64(wr, sz, sgn, a, {$urandom, $urandom}, {$urandom, $urandom});
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
